// File: rtl/adex_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : adex_pkg
//  Purpose  : Shared constants, rate-class encodings and small ISI helpers
//             used by the spike-rate monitor and its record FIFO.
//  Revision : 1.0 - initial release
// ============================================================================
package adex_pkg;

    // Width of every inter-spike-interval quantity.
    localparam int ISI_W = 16;

    // Saturation value for ISI counters; also the "no interval seen" marker.
    localparam logic [ISI_W-1:0] ISI_MAX = {ISI_W{1'b1}};

    // Value loaded into the ISI counter on a spike.
    localparam logic [ISI_W-1:0] ISI_ONE = ISI_W'(1);

    // Rate classification carried in each record.
    typedef enum logic [1:0] {
        CLS_NORMAL = 2'd0,
        CLS_LOW    = 2'd1,
        CLS_HIGH   = 2'd2
    } rate_class_e;

    // Saturating increment of an ISI counter.
    function automatic logic [ISI_W-1:0] isi_sat_inc(input logic [ISI_W-1:0] a);
        return (a == ISI_MAX) ? a : a + ISI_ONE;
    endfunction

    // Smaller of two intervals.
    function automatic logic [ISI_W-1:0] isi_min(input logic [ISI_W-1:0] a,
                                                 input logic [ISI_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spike_rec_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : spike_rec_fifo
//  Purpose  : First-word-fall-through record FIFO with occupancy counter.
//             A push into a full FIFO is taken only when a pop happens in
//             the same cycle; otherwise it is discarded and flagged.
//  Revision : 1.0 - initial release
// ============================================================================
module spike_rec_fifo #(
    parameter int WIDTH = 28,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o,
    output logic             overflow_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             full;
    logic             do_push;
    logic             do_pop;

    // Handshake qualification, pointer and occupancy next-state.
    always_comb begin
        full       = (level_q == LVL_FULL);
        empty_o    = (level_q == '0);
        do_pop     = pop_i & ~empty_o;
        // When full, the slot being vacated by the pop is exactly wr_ptr.
        do_push    = push_i & (~full | do_pop);
        overflow_o = push_i & full & ~do_pop;
        wr_ptr_d   = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        level_d    = level_q;
        if (do_push && !do_pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (!do_push && do_pop) begin
            level_d = level_q - LVL_W'(1);
        end
        head_o     = mem_q[rd_ptr_q];
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Record storage; contents are only visible through a valid head.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/spike_rate_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : spike_rate_monitor
//  Purpose  : Counts spikes over fixed windows, tracks the minimum
//             inter-spike interval, classifies the rate and queues one
//             {count, class, isi_min} record per window for downstream.
//  Revision : 1.0 - initial release
// ============================================================================
module spike_rate_monitor
    import adex_pkg::*;
#(
    parameter int WIN_CYCLES = 1000,
    parameter int CNT_W      = 10,
    parameter int TH_LO      = 2,
    parameter int TH_HI      = 8,
    parameter int DEPTH      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             spikes,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [CNT_W-1:0] out_count,
    output logic [1:0]       out_class,
    output logic [ISI_W-1:0] out_isi_min,
    output logic             drop
);

    localparam int                WIN_W    = (WIN_CYCLES > 1) ? $clog2(WIN_CYCLES) : 1;
    localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(WIN_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  TH_LO_C  = CNT_W'(TH_LO);
    localparam logic [CNT_W-1:0]  TH_HI_C  = CNT_W'(TH_HI);
    localparam int                REC_W    = CNT_W + 2 + ISI_W;

    logic [WIN_W-1:0] win_q, win_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ISI_W-1:0] isi_q, isi_d;
    logic [ISI_W-1:0] isi_min_q, isi_min_d;
    logic             seen_q, seen_d;
    logic             drop_q, drop_d;

    logic             win_last;
    logic [CNT_W-1:0] cnt_final;
    logic [ISI_W-1:0] isi_min_final;
    rate_class_e      cls_final;

    logic [REC_W-1:0] rec_in;
    logic [REC_W-1:0] fifo_head;
    logic             fifo_empty;
    logic             fifo_overflow;
    logic             pop;

    // Window bookkeeping: the "final" values already include this cycle's
    // spike so a spike in the last cycle lands in the closing record.
    always_comb begin
        win_last      = (win_q == WIN_LAST);

        cnt_final     = cnt_q;
        if (spikes && (cnt_q != CNT_MAX)) begin
            cnt_final = cnt_q + CNT_W'(1);
        end

        // Only an interval between two spikes of the same window counts.
        isi_min_final = isi_min_q;
        if (spikes && seen_q) begin
            isi_min_final = isi_min(isi_min_q, isi_q);
        end

        isi_d         = spikes ? ISI_ONE : isi_sat_inc(isi_q);

        if (win_last) begin
            win_d     = '0;
            cnt_d     = '0;
            isi_min_d = ISI_MAX;
            seen_d    = 1'b0;
        end else begin
            win_d     = win_q + WIN_W'(1);
            cnt_d     = cnt_final;
            isi_min_d = isi_min_final;
            seen_d    = seen_q | spikes;
        end
    end

    // Rate classification of the closing window's final count.
    always_comb begin
        cls_final = CLS_NORMAL;
        if (cnt_final < TH_LO_C) begin
            cls_final = CLS_LOW;
        end else if (cnt_final > TH_HI_C) begin
            cls_final = CLS_HIGH;
        end
    end

    // Record assembly, handshake and sticky drop next-state.
    always_comb begin
        rec_in = {cnt_final, cls_final, isi_min_final};
        pop    = out_valid & out_ready;
        drop_d = drop_q | fifo_overflow;
    end

    // Window, count, ISI and drop state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_q     <= '0;
            cnt_q     <= '0;
            isi_q     <= ISI_MAX;
            isi_min_q <= ISI_MAX;
            seen_q    <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            win_q     <= win_d;
            cnt_q     <= cnt_d;
            isi_q     <= isi_d;
            isi_min_q <= isi_min_d;
            seen_q    <= seen_d;
            drop_q    <= drop_d;
        end
    end

    spike_rec_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (win_last),
        .push_data_i (rec_in),
        .pop_i       (pop),
        .empty_o     (fifo_empty),
        .head_o      (fifo_head),
        .overflow_o  (fifo_overflow)
    );

    // Present the FIFO head; idle fields show the reset values.
    always_comb begin
        out_valid = ~fifo_empty;
        if (fifo_empty) begin
            out_count   = '0;
            out_class   = CLS_NORMAL;
            out_isi_min = ISI_MAX;
        end else begin
            {out_count, out_class, out_isi_min} = fifo_head;
        end
        drop = drop_q;
    end

endmodule
`default_nettype wire
